// File: rtl/ow_pkg.sv
// Shared 1-Wire master definitions: command and CRC-mode encodings, engine
// states, microsecond timing constants and the per-phase duration lookup.
package ow_pkg;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'b00,
        CMD_BUS_RESET = 2'b01,
        CMD_WRITE     = 2'b10,
        CMD_READ      = 2'b11
    } ow_cmd_e;

    typedef enum logic [1:0] {
        CRC_IDLE  = 2'b00,
        CRC_RESET = 2'b01,
        CRC_WRITE = 2'b10,
        CRC_READ  = 2'b11
    } crc_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_SAMPLE,
        ST_RST_REC,
        ST_SLOT_LOW,
        ST_SLOT_HOLD,
        ST_SLOT_REC,
        ST_FINISH
    } ow_state_e;

    // Width of the per-phase microsecond counter (longest phase is 480 us)
    localparam int unsigned US_W = 9;

    localparam int unsigned T_RST_LOW_US    = 480;
    localparam int unsigned T_RST_SAMPLE_US = 70;
    localparam int unsigned T_RST_REC_US    = 410;
    localparam int unsigned T_W0_LOW_US     = 60;
    localparam int unsigned T_RD_SAMPLE_US  = 15;
    localparam int unsigned T_SHORT_LOW_US  = 6;
    localparam int unsigned T_SLOT_US       = 70;
    localparam int unsigned T_W0_REC_US     = 10;

    // Slot split for read and write-1: low, released up to the sample point, rest of slot
    localparam int unsigned T_HOLD_US = T_RD_SAMPLE_US - T_SHORT_LOW_US;
    localparam int unsigned T_REC_US  = T_SLOT_US - T_RD_SAMPLE_US;

    // Duration in microseconds of the phase held in st; bit_val is the write bit in flight
    function automatic logic [US_W-1:0] phase_us(ow_state_e st, ow_cmd_e cmd, logic bit_val);
        logic [US_W-1:0] us;
        logic            wr0;
        wr0 = (cmd == CMD_WRITE) && !bit_val;
        us  = US_W'(1);
        case (st)
            ST_RST_LOW:    us = US_W'(T_RST_LOW_US);
            ST_RST_SAMPLE: us = US_W'(T_RST_SAMPLE_US);
            ST_RST_REC:    us = US_W'(T_RST_REC_US);
            ST_SLOT_LOW:   us = wr0 ? US_W'(T_W0_LOW_US) : US_W'(T_SHORT_LOW_US);
            ST_SLOT_HOLD:  us = US_W'(T_HOLD_US);
            ST_SLOT_REC:   us = wr0 ? US_W'(T_W0_REC_US) : US_W'(T_REC_US);
            default:       us = US_W'(1);
        endcase
        return us;
    endfunction

endpackage

// File: rtl/ow_us_tick.sv
// Microsecond prescaler: one-cycle us_tick_c every CLK_PER_US clocks.
// Ports: clk, rst (async active-low), clr_i (sync restart of the count),
//        us_tick_c (combinational tick, high in the last cycle of each microsecond).
module ow_us_tick
    import ow_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic us_tick_c
);

    localparam int unsigned    CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_US - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap at the end of each microsecond or restart on request
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so a phase of T us lasts exactly T*CLK_PER_US cycles
    assign us_tick_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ow_master_engine.sv
// 1-Wire bus master engine: bus reset with presence detect, byte write and
// byte read (LSB first), with a one-cycle CRC feed at command completion.
// Ports: clk, rst (async active-low); start/cmd/tx_byte command request;
//        ow_in sampled line, ow_drive_low pull-down enable; busy, done,
//        presence, rx_byte status; crc_mode/crc_data downstream CRC feed.
module ow_master_engine
    import ow_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_byte,
    input  logic       ow_in,
    output logic       ow_drive_low,
    output logic       busy,
    output logic       done,
    output logic       presence,
    output logic [7:0] rx_byte,
    output logic [1:0] crc_mode,
    output logic [7:0] crc_data
);

    ow_state_e       state_q, state_d;
    ow_cmd_e         cmd_q, cmd_d;
    logic [US_W-1:0] us_q, us_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      tx_q, tx_d;
    logic            drive_q, drive_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pres_q, pres_d;
    logic [7:0]      rx_q, rx_d;
    logic [1:0]      crc_mode_q, crc_mode_d;
    logic [7:0]      crc_data_q, crc_data_d;

    ow_cmd_e         cmd_c;
    logic            us_tick_c;
    logic            clr_c;
    logic            phase_end_c;

    assign cmd_c       = ow_cmd_e'(cmd);
    assign clr_c       = (state_d != state_q);
    assign phase_end_c = us_tick_c && (us_q == (phase_us(state_q, cmd_q, sh_q[0]) - US_W'(1)));

    ow_us_tick #(
        .CLK_PER_US(CLK_PER_US)
    ) u_us_tick (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_c),
        .us_tick_c(us_tick_c)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        us_d       = us_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        pres_d     = pres_q;
        rx_d       = rx_q;
        crc_mode_d = CRC_IDLE;
        crc_data_d = '0;

        if (us_tick_c) begin
            us_d = us_q + US_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                us_d = '0;
                if (start && (cmd_c != CMD_NOP)) begin
                    cmd_d   = cmd_c;
                    tx_d    = tx_byte;
                    sh_d    = tx_byte;
                    bit_d   = '0;
                    state_d = (cmd_c == CMD_BUS_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
                end
            end
            ST_RST_LOW: begin
                if (phase_end_c) state_d = ST_RST_SAMPLE;
            end
            ST_RST_SAMPLE: begin
                if (phase_end_c) begin
                    pres_d  = ~ow_in;
                    state_d = ST_RST_REC;
                end
            end
            ST_RST_REC: begin
                if (phase_end_c) state_d = ST_FINISH;
            end
            ST_SLOT_LOW: begin
                // A write-0 low phase already spans the sample point
                if (phase_end_c) begin
                    state_d = ((cmd_q == CMD_WRITE) && !sh_q[0]) ? ST_SLOT_REC : ST_SLOT_HOLD;
                end
            end
            ST_SLOT_HOLD: begin
                if (phase_end_c) begin
                    if (cmd_q == CMD_READ) sh_d = {ow_in, sh_q[7:1]};
                    state_d = ST_SLOT_REC;
                end
            end
            ST_SLOT_REC: begin
                if (phase_end_c) begin
                    if (cmd_q == CMD_WRITE) sh_d = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_FINISH;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = ST_SLOT_LOW;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            us_d = '0;
        end

        // Completion results and CRC feed land together with done
        if (state_d == ST_FINISH) begin
            unique case (cmd_q)
                CMD_WRITE: begin
                    crc_mode_d = CRC_WRITE;
                    crc_data_d = tx_q;
                end
                CMD_READ: begin
                    crc_mode_d = CRC_READ;
                    crc_data_d = sh_q;
                    rx_d       = sh_q;
                end
                default: begin
                    crc_mode_d = CRC_RESET;
                end
            endcase
        end

        drive_d = (state_d == ST_RST_LOW) || (state_d == ST_SLOT_LOW);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NOP;
            us_q       <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            tx_q       <= '0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pres_q     <= 1'b0;
            rx_q       <= '0;
            crc_mode_q <= CRC_IDLE;
            crc_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            us_q       <= us_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pres_q     <= pres_d;
            rx_q       <= rx_d;
            crc_mode_q <= crc_mode_d;
            crc_data_q <= crc_data_d;
        end
    end

    assign ow_drive_low = drive_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign presence     = pres_q;
    assign rx_byte      = rx_q;
    assign crc_mode     = crc_mode_q;
    assign crc_data     = crc_data_q;

endmodule

// File: tb/tb_ow_master_engine.sv
// Scoreboard bench for ow_master_engine at CLK_PER_US=2: stimulus queues the
// expected low-pulse widths and done-cycle results; a monitor pops and compares.
module tb_ow_master_engine;

    localparam int unsigned N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] tx_byte;
    logic       ow_in;
    logic       ow_drive_low;
    logic       busy;
    logic       done;
    logic       presence;
    logic [7:0] rx_byte;
    logic [1:0] crc_mode;
    logic [7:0] crc_data;

    always #5 clk = ~clk;

    ow_master_engine #(
        .CLK_PER_US(N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmd         (cmd),
        .tx_byte     (tx_byte),
        .ow_in       (ow_in),
        .ow_drive_low(ow_drive_low),
        .busy        (busy),
        .done        (done),
        .presence    (presence),
        .rx_byte     (rx_byte),
        .crc_mode    (crc_mode),
        .crc_data    (crc_data)
    );

    typedef struct packed {
        logic       pres;
        logic [7:0] rx;
        logic [1:0] mode;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pw_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endfunction

    // Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected), the downstream unit
    function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] d);
        logic [7:0] c;
        logic [7:0] b;
        logic       mix;
        c = crc_in;
        b = d;
        for (int i = 0; i < 8; i++) begin
            mix = c[0] ^ b[0];
            c   = c >> 1;
            if (mix) c = c ^ 8'h8C;
            b = b >> 1;
        end
        return c;
    endfunction

    // Slave device: presence pulse after a reset release, or zeros in read slots
    logic       dev_low  = 1'b0;
    logic       drv_prev = 1'b0;
    logic       pres_en  = 1'b0;
    logic       read_en  = 1'b0;
    logic [7:0] dev_byte = 8'h00;
    int         rel_cnt  = 1000000;
    int         slot_cnt = 1000000;
    int         dev_bit  = -1;

    assign ow_in = ~ow_drive_low & ~dev_low;

    always @(negedge clk) begin
        if (!ow_drive_low && drv_prev) rel_cnt = 0;
        else rel_cnt++;
        if (ow_drive_low && !drv_prev) begin
            slot_cnt = 0;
            dev_bit++;
        end else begin
            slot_cnt++;
        end
        drv_prev = ow_drive_low;
        // Presence: 30 us after release, held low for 150 us
        dev_low = (pres_en && (rel_cnt >= int'(30 * N)) && (rel_cnt < int'(180 * N))) ||
                  (read_en && (dev_bit >= 0) && (dev_bit < 8) && (slot_cnt < int'(30 * N)) &&
                   !dev_byte[dev_bit[2:0]]);
    end

    // Monitor: pulse widths, done-cycle results, CRC feed model
    int         run        = 0;
    int         done_seen  = 0;
    logic [7:0] crc_model  = 8'h00;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst) begin
            run       = 0;
            crc_model = 8'h00;
        end else begin
            if (ow_drive_low) begin
                run++;
            end else if (run != 0) begin
                if (pw_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_unexpected: width %0d cycles, none expected", run);
                end else begin
                    chk("pulse_width", run, pw_q.pop_front());
                end
                run = 0;
            end
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done pulse with nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_presence", presence, e.pres);
                    chk("done_rx_byte", rx_byte, e.rx);
                    chk("done_crc_mode", crc_mode, e.mode);
                    chk("done_crc_data", crc_data, e.data);
                end
            end else if (crc_mode != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL crc_mode_outside_done: got %0b, expected 00", crc_mode);
            end
            case (crc_mode)
                2'b01:   crc_model = 8'h00;
                2'b10,
                2'b11:   crc_model = crc8(crc_model, crc_data);
                default: crc_model = crc_model;
            endcase
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] b);
        @(negedge clk);
        cmd     = c;
        tx_byte = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cmd     = 2'b00;
    endtask

    task automatic wait_done(input string name, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic push_write_pulses(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            pw_q.push_back(b[i] ? int'(6 * N) : int'(60 * N));
        end
    endtask

    int lat;
    int d0;

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        cmd     = 2'b00;
        tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_drive", ow_drive_low, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_presence", presence, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_crc_mode", crc_mode, 0);
        chk("rst_crc_data", crc_data, 0);
        rst = 1'b1;

        // Bus reset with a presence pulse
        pres_en = 1'b1;
        pw_q.push_back(480 * N);
        exp_q.push_back('{1'b1, 8'h00, 2'b01, 8'h00});
        issue(2'b01, 8'h00);
        chk("busy_after_accept", busy, 1);
        wait_done("reset_presence", 4000, lat);
        chk("reset_latency", lat, 1920);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        pres_en = 1'b0;

        // Bus reset with no device
        pw_q.push_back(480 * N);
        exp_q.push_back('{1'b0, 8'h00, 2'b01, 8'h00});
        issue(2'b01, 8'h00);
        wait_done("reset_absent", 4000, lat);
        @(negedge clk);

        // NOP is ignored
        issue(2'b00, 8'hFF);
        chk("nop_busy", busy, 0);

        // Write A5
        push_write_pulses(8'hA5);
        exp_q.push_back('{1'b0, 8'h00, 2'b10, 8'hA5});
        issue(2'b10, 8'hA5);
        wait_done("write_a5", 2500, lat);
        chk("write_latency", lat, 1120);
        @(negedge clk);

        // Write 0F with a start pulsed while busy
        d0 = done_seen;
        push_write_pulses(8'h0F);
        exp_q.push_back('{1'b0, 8'h00, 2'b10, 8'h0F});
        issue(2'b10, 8'h0F);
        repeat (50) @(negedge clk);
        issue(2'b11, 8'h55);
        wait_done("write_0f", 2500, lat);
        repeat (300) @(negedge clk);
        chk("busy_start_done_count", done_seen - d0, 1);

        // CRC seed via bus reset, then read 3C
        pw_q.push_back(480 * N);
        exp_q.push_back('{1'b0, 8'h00, 2'b01, 8'h00});
        issue(2'b01, 8'h00);
        wait_done("reset_seed", 4000, lat);
        @(negedge clk);
        dev_byte = 8'h3C;
        dev_bit  = -1;
        read_en  = 1'b1;
        for (int i = 0; i < 8; i++) pw_q.push_back(6 * N);
        exp_q.push_back('{1'b0, 8'h3C, 2'b11, 8'h3C});
        issue(2'b11, 8'h00);
        wait_done("read_3c", 2500, lat);
        @(negedge clk);
        read_en = 1'b0;
        chk("read_rx_hold", rx_byte, 8'h3C);
        chk("crc_remainder", crc_model, 8'h1D);

        // Reset mid low phase of a write-0 slot
        d0 = done_seen;
        issue(2'b10, 8'h00);
        repeat (20) @(negedge clk);
        chk("abort_pre_drive", ow_drive_low, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_drive", ow_drive_low, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rx_byte", rx_byte, 0);
        chk("abort_crc_mode", crc_mode, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (400) @(negedge clk);
        chk("abort_done_count", done_seen - d0, 0);

        // Bus reset after the abort runs normally
        pres_en = 1'b1;
        pw_q.push_back(480 * N);
        exp_q.push_back('{1'b1, 8'h00, 2'b01, 8'h00});
        issue(2'b01, 8'h00);
        wait_done("reset_after_abort", 4000, lat);
        chk("reset_after_abort_latency", lat, 1920);
        @(negedge clk);
        pres_en = 1'b0;
        chk("final_busy", busy, 0);
        chk("scoreboard_drained", exp_q.size() + pw_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
